elem_fetch_cache: RTL and testbench
===================================

Name: elem_fetch_cache

Overview:
- Parametrised successor of the single-element cached SDRAM reader.
- Fetches fixed-size array elements (NDWORDS x 32 bit) from SDRAM over a 16-bit Avalon-MM master and holds them in a direct-mapped cache with 2^IDX_BITS lines.
- Front side uses full ivalid/iready and ovalid/oready handshakes, so consumers such as the ray/triangle fetch stage can stall.
- Adds explicit invalidate, pipelined miss bursts, and hit/miss counters.

Parameters:
- NDWORDS, 9, 32-bit words per element; each miss reads NHALF = 2*NDWORDS halfwords.
- IDX_BITS, 4, cache line-index bits; 2^IDX_BITS lines.
- ELEMSZ, 32*NDWORDS, element width. Derived; never overridden.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- baseaddr  in  32  array byte base address; quasi-static, sampled at miss start.
- index  in  32  element index; sampled when ivalid && iready.
- ivalid  in  1  request valid.
- iready  out  1  request accepted this cycle when ivalid is also high.
- data  out  ELEMSZ  element data; halfword k occupies bits [16k+15:16k].
- ovalid  out  1  response valid.
- oready  in  1  consumer accepts the response.
- invalidate  in  1  clears all cache valid bits.
- hit_count  out  32  saturating count of hits.
- miss_count  out  32  saturating count of misses.
- avm_m0_read  out  1  Avalon read.
- avm_m0_address  out  32  Avalon byte address.
- avm_m0_byteenable  out  2  Avalon byte enables; constant 2'b11.
- avm_m0_readdata  in  16  Avalon read data.
- avm_m0_readdatavalid  in  1  Avalon read data valid.
- avm_m0_waitrequest  in  1  Avalon wait request.

Behaviour:
- Reset values: iready=0, ovalid=0, avm_m0_read=0, avm_m0_address=0, data=0, both counters=0, all valid bits=0, state IDLE. Reset mid-fill abandons the burst. Readdatavalid pulses arriving in IDLE are ignored.
- Line = index[IDX_BITS-1:0]. Tag = index[31:IDX_BITS]. Element byte address = baseaddr + index*4*NDWORDS, computed modulo 2^32.
- Only one request is in flight; responses are returned in order.
- iready = (state==IDLE) || (state==RESP && oready). Accepting in RESP allows back-to-back hits at one per cycle.
- On accept, tag compare and valid check use the current arrays.
- Hit: goes to RESP. data and ovalid are registered and appear on the next cycle (latency 1). hit_count increments.
- Miss: goes to ISSUE. miss_count increments. fill_addr is loaded with the element address; issue and receive counters are cleared.
- ISSUE:
  - avm_m0_read=1 and address=fill_addr.
  - Each cycle with waitrequest=0 counts one issued read and adds 2 to fill_addr.
  - After NHALF reads have been issued, read drops and the state moves to WAIT.
  - Reads are pipelined: data may return while reads are still being issued.
- Receive path (active in ISSUE and WAIT): each readdatavalid writes readdata into halfword slot rcv_cnt of the line buffer; rcv_cnt increments.
- Last halfword received (rcv_cnt == NHALF-1 with readdatavalid): writes the line, tag, and valid=1, then goes to RESP with ovalid on the next cycle.
- RESP: ovalid and data are held stable until oready=1.
  - oready && ivalid: the next request is accepted (hit → RESP, miss → ISSUE).
  - oready && !ivalid: goes to IDLE.
- invalidate:
  - Clears all valid bits on the next edge.
  - If asserted during ISSUE or WAIT, the fill completes and the data is returned, but that line stays invalid.
  - If asserted in the same cycle as a hit lookup, the hit is still served from the pre-clear arrays.
- Counters saturate at 32'hFFFFFFFF.
- States (shared enum): IDLE, ISSUE, WAIT, RESP.

Decomposition:
- Package elem_fetch_pkg holds the state enum and NHALF/address-stride helper functions.
- One sub-module, elem_cache_dm: tag, valid and data arrays, with a read/compare port, a write port and an invalidate-all input.
- The FSM, Avalon burst engine and counters live in elem_fetch_cache.

Test Plan:
- Cold miss: baseaddr=0x1000, index=2, NDWORDS=9, no waitrequest.
  - 18 reads at 0x1048..0x106A in steps of 2.
  - Memory returns halfwords 0x0000..0x0011 → data slot k = k, ovalid=1.
  - miss_count=1.
- Repeat index=2 after the response is taken → ovalid exactly 1 cycle after accept, no Avalon read, hit_count=1.
- Back-to-back hits on indices 2,2,2 with oready=1 held → ovalid high 3 consecutive cycles, iready held high.
- Conflict: index 2, then index 18 (same line, IDX_BITS=4) → second request misses (address 0x1000+18*36), then index 2 misses again.
- Waitrequest stalls on every 2nd cycle, readdatavalid with 3-cycle latency → all 18 halfwords land in order; data matches memory.
- Stall and invalidate: hold oready=0 for 5 cycles → data stable. Pulse invalidate mid-fill → response still delivered; next request to the same index misses. Assert reset during ISSUE → all outputs return to 0 immediately.

Source files
------------

// File: rtl/elem_fetch_pkg.sv
// Shared types and address helpers for the cached SDRAM element fetcher.
package elem_fetch_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} fetch_state_t;

   function automatic int unsigned nhalf(input int unsigned ndwords);
      return 2 * ndwords;
   endfunction

   function automatic logic [31:0] elem_stride(input int unsigned ndwords);
      return 32'(4 * ndwords);
   endfunction

   // Byte address of an element; wraps modulo 2^32.
   function automatic logic [31:0] elem_addr(input logic [31:0] base,
                                             input logic [31:0] idx,
                                             input int unsigned ndwords);
      return base + idx * elem_stride(ndwords);
   endfunction

endpackage

// File: rtl/elem_cache_dm.sv
// Direct-mapped element store: tag/valid/data arrays with combinational lookup,
// one write port and a clear-all for the valid bits.
module elem_cache_dm
   import elem_fetch_pkg::*;
#(
   parameter int unsigned IDX_BITS = 4,
   parameter int unsigned TAG_BITS = 28,
   parameter int unsigned ELEMSZ   = 288
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IDX_BITS-1:0] rd_line,
   input  logic [TAG_BITS-1:0] rd_tag,
   output logic                rd_hit,
   output logic [ELEMSZ-1:0]   rd_data,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_line,
   input  logic [TAG_BITS-1:0] wr_tag,
   input  logic [ELEMSZ-1:0]   wr_data,
   input  logic                wr_valid,
   input  logic                inv_all
);

   localparam int unsigned NLINES = 1 << IDX_BITS;

   logic [NLINES-1:0]   valid;
   logic [TAG_BITS-1:0] tags  [NLINES];
   logic [ELEMSZ-1:0]   lines [NLINES];

   // Clear-all dominates a simultaneous fill so the filled line stays invalid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= '0;
      end else if (inv_all) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_line] <= wr_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_line]  <= wr_tag;
         lines[wr_line] <= wr_data;
      end
   end

   always_comb begin
      rd_hit  = valid[rd_line] && (tags[rd_line] == rd_tag);
      rd_data = lines[rd_line];
   end

endmodule

// File: rtl/elem_fetch_cache.sv
// Cached element fetcher: handshake front end, direct-mapped cache and a
// pipelined 16-bit Avalon-MM burst engine that fills one element per miss.
module elem_fetch_cache
   import elem_fetch_pkg::*;
#(
   parameter  int unsigned NDWORDS  = 9,
   parameter  int unsigned IDX_BITS = 4,
   localparam int unsigned ELEMSZ   = 32 * NDWORDS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       baseaddr,
   input  logic [31:0]       index,
   input  logic              ivalid,
   output logic              iready,
   output logic [ELEMSZ-1:0] data,
   output logic              ovalid,
   input  logic              oready,
   input  logic              invalidate,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count,
   output logic              avm_m0_read,
   output logic [31:0]       avm_m0_address,
   output logic [1:0]        avm_m0_byteenable,
   input  logic [15:0]       avm_m0_readdata,
   input  logic              avm_m0_readdatavalid,
   input  logic              avm_m0_waitrequest
);

   localparam int unsigned NHALF    = nhalf(NDWORDS);
   localparam int unsigned CW       = $clog2(NHALF + 1);
   localparam int unsigned TAG_BITS = 32 - IDX_BITS;
   localparam logic [CW-1:0] LAST   = CW'(NHALF - 1);

   fetch_state_t state, state_nxt;

   logic [31:0]          fill_addr;
   logic [CW-1:0]        iss_cnt, rcv_cnt;
   logic [ELEMSZ-17:0]   lbuf;
   logic [IDX_BITS-1:0]  req_line;
   logic [TAG_BITS-1:0]  req_tag;
   logic                 fill_killed;
   logic                 accept, lookup_hit, fill_active, iss_go, last_rcv;
   logic [ELEMSZ-1:0]    lookup_data, fill_line;

   assign avm_m0_byteenable = 2'b11;
   assign avm_m0_read       = (state == ISSUE);
   assign avm_m0_address    = fill_addr;

   elem_cache_dm #(
      .IDX_BITS (IDX_BITS),
      .TAG_BITS (TAG_BITS),
      .ELEMSZ   (ELEMSZ)
   ) u_cache (
      .clk      (clk),
      .reset    (reset),
      .rd_line  (index[IDX_BITS-1:0]),
      .rd_tag   (index[31:IDX_BITS]),
      .rd_hit   (lookup_hit),
      .rd_data  (lookup_data),
      .wr_en    (last_rcv),
      .wr_line  (req_line),
      .wr_tag   (req_tag),
      .wr_data  (fill_line),
      .wr_valid (!fill_killed),
      .inv_all  (invalidate)
   );

   always_comb begin
      iready      = !reset && ((state == IDLE) || ((state == RESP) && oready));
      accept      = ivalid && iready;
      fill_active = (state == ISSUE) || (state == WAIT);
      iss_go      = (state == ISSUE) && !avm_m0_waitrequest;
      last_rcv    = fill_active && avm_m0_readdatavalid && (rcv_cnt == LAST);
      fill_line   = {avm_m0_readdata, lbuf};
      state_nxt   = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = lookup_hit ? RESP : ISSUE;
         end
         RESP: begin
            if (accept)      state_nxt = lookup_hit ? RESP : ISSUE;
            else if (oready) state_nxt = IDLE;
         end
         ISSUE: begin
            if (iss_go && (iss_cnt == LAST)) state_nxt = WAIT;
            if (last_rcv)                    state_nxt = RESP;
         end
         WAIT: begin
            if (last_rcv) state_nxt = RESP;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill_addr   <= '0;
         iss_cnt     <= '0;
         rcv_cnt     <= '0;
         lbuf        <= '0;
         req_line    <= '0;
         req_tag     <= '0;
         fill_killed <= 1'b0;
         data        <= '0;
         ovalid      <= 1'b0;
         hit_count   <= '0;
         miss_count  <= '0;
      end else begin
         if (accept) begin
            if (lookup_hit) begin
               data   <= lookup_data;
               ovalid <= 1'b1;
               if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else begin
               ovalid      <= 1'b0;
               fill_addr   <= elem_addr(baseaddr, index, NDWORDS);
               iss_cnt     <= '0;
               rcv_cnt     <= '0;
               req_line    <= index[IDX_BITS-1:0];
               req_tag     <= index[31:IDX_BITS];
               // An invalidate coinciding with the miss accept also covers this fill.
               fill_killed <= invalidate;
               if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
         end else if ((state == RESP) && oready) begin
            ovalid <= 1'b0;
         end

         if (iss_go) begin
            iss_cnt   <= iss_cnt + 1'b1;
            fill_addr <= fill_addr + 32'd2;
         end

         if (fill_active && avm_m0_readdatavalid) begin
            rcv_cnt <= rcv_cnt + 1'b1;
            if (!last_rcv) lbuf[{rcv_cnt, 4'b0000} +: 16] <= avm_m0_readdata;
         end

         if (last_rcv) begin
            data   <= fill_line;
            ovalid <= 1'b1;
         end

         if (fill_active && invalidate) fill_killed <= 1'b1;
      end
   end

endmodule

// File: tb/tb_elem_fetch_cache.sv
// Scoreboard bench for elem_fetch_cache: behavioural cache model, Avalon memory
// responder with configurable stalls/latency, and an independent response monitor.
module tb_elem_fetch_cache;

   localparam int unsigned NDW  = 9;
   localparam int unsigned IDXB = 4;
   localparam int unsigned ESZ  = 32 * NDW;
   localparam int unsigned NH   = 2 * NDW;

   logic            clk, reset;
   logic [31:0]     baseaddr, index;
   logic            ivalid, iready, ovalid, oready, invalidate;
   logic [ESZ-1:0]  data;
   logic [31:0]     hit_count, miss_count;
   logic            avm_read;
   logic [31:0]     avm_addr;
   logic [1:0]      avm_be;
   logic [15:0]     rdata;
   logic            rdv, wreq;

   elem_fetch_cache #(.NDWORDS(NDW), .IDX_BITS(IDXB)) dut (
      .clk                  (clk),
      .reset                (reset),
      .baseaddr             (baseaddr),
      .index                (index),
      .ivalid               (ivalid),
      .iready               (iready),
      .data                 (data),
      .ovalid               (ovalid),
      .oready               (oready),
      .invalidate           (invalidate),
      .hit_count            (hit_count),
      .miss_count           (miss_count),
      .avm_m0_read          (avm_read),
      .avm_m0_address       (avm_addr),
      .avm_m0_byteenable    (avm_be),
      .avm_m0_readdata      (rdata),
      .avm_m0_readdatavalid (rdv),
      .avm_m0_waitrequest   (wreq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [ESZ-1:0] act, input logic [ESZ-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   // Memory contents: a fixed function of the byte address.
   function automatic logic [15:0] mem_hw(input logic [31:0] a);
      logic [31:0] d;
      d = (a - 32'h1048) >> 1;
      return d[15:0] ^ a[31:16];
   endfunction

   function automatic logic [ESZ-1:0] elem_data(input logic [31:0] ea);
      logic [ESZ-1:0] r;
      for (int k = 0; k < NH; k++) r[16*k +: 16] = mem_hw(ea + 32'(2 * k));
      return r;
   endfunction

   // Reference cache: per line, the full element index it holds.
   bit             mv [16];
   logic [31:0]    mi [16];
   logic [ESZ-1:0] md [16];
   int unsigned    m_hits = 0, m_misses = 0;

   typedef struct {
      logic [ESZ-1:0] data;
      bit             is_hit;
      int unsigned    acc_cyc;
      int unsigned    nreads;
   } exp_t;
   exp_t sbq[$];

   task automatic model_clear();
      for (int i = 0; i < 16; i++) mv[i] = 0;
   endtask

   task automatic model_accept(input logic [31:0] idx);
      exp_t        e;
      int unsigned line;
      logic [31:0] ea;
      line = idx % 16;
      ea   = baseaddr + idx * 32'd36;
      e.acc_cyc = cyc;
      if (mv[line] && mi[line] == idx) begin
         e.is_hit = 1;
         e.data   = md[line];
         e.nreads = 0;
         m_hits++;
      end else begin
         e.is_hit = 0;
         e.data   = elem_data(ea);
         e.nreads = NH;
         md[line] = e.data;
         mi[line] = idx;
         mv[line] = 1;
         m_misses++;
      end
      sbq.push_back(e);
   endtask

   // Avalon memory responder.
   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } rd_t;
   rd_t         pend[$];
   int          wr_mode = 0;
   int unsigned lat = 1;
   int unsigned reads_seen = 0;

   initial begin
      rd_t r;
      wreq  = 1'b0;
      rdv   = 1'b0;
      rdata = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pend.delete();
            rdv  = 1'b0;
            wreq = 1'b0;
         end else begin
            rdv = 1'b0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
               r     = pend.pop_front();
               rdv   = 1'b1;
               rdata = mem_hw(r.addr);
            end
            case (wr_mode)
               0:       wreq = 1'b0;
               1:       wreq = cyc[0];
               default: wreq = ($urandom_range(0, 2) == 0);
            endcase
            if (avm_read && !wreq) begin
               pend.push_back('{avm_addr, cyc + lat});
               reads_seen++;
            end
         end
      end
   end

   // Consumer and response monitor.
   int          or_mode = 0;
   bit          cur_seen = 0;
   int unsigned reads_at_pop = 0;

   initial begin
      oready = 1'b0;
      forever begin
         @(negedge clk);
         case (or_mode)
            0:       oready = 1'b1;
            1:       oready = 1'($urandom_range(0, 1));
            default: oready = 1'b0;
         endcase
         #2;
         if (!reset && ovalid) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ovalid got 1 want 0");
            end else begin
               if (!cur_seen) begin
                  cur_seen = 1;
                  if (sbq[0].is_hit)
                     check("hit_latency", ESZ'(cyc), ESZ'(sbq[0].acc_cyc + 1));
               end
               check("data", data, sbq[0].data);
               if (oready) begin
                  check("reads_per_req", ESZ'(reads_seen - reads_at_pop), ESZ'(sbq[0].nreads));
                  reads_at_pop = reads_seen;
                  void'(sbq.pop_front());
                  cur_seen = 0;
               end
            end
         end
      end
   end

   // Driver tasks: entered and left on a falling edge.
   task automatic idle_cycles(input int n);
      ivalid = 1'b0;
      repeat (n) begin
         #1;
         if (invalidate) model_clear();
         @(negedge clk);
         invalidate = 1'b0;
      end
   endtask

   task automatic pulse_inv();
      invalidate = 1'b1;
      idle_cycles(1);
   endtask

   task automatic do_req(input logic [31:0] idx, input bit inv = 0);
      bit acc;
      int n;
      ivalid     = 1'b1;
      index      = idx;
      invalidate = inv;
      n = 0;
      forever begin
         #1;
         acc = iready;
         if (acc) model_accept(idx);
         if (invalidate) model_clear();
         @(negedge clk);
         invalidate = 1'b0;
         if (acc) break;
         if (++n > 5000) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got 0 want 1");
            break;
         end
      end
   endtask

   task automatic wait_drain();
      int n;
      ivalid = 1'b0;
      n = 0;
      while (sbq.size() != 0 && n < 5000) begin
         idle_cycles(1);
         n++;
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout got %0d want 0", sbq.size());
      end
   endtask

   task automatic check_counters();
      check("hit_count", ESZ'(hit_count), ESZ'(m_hits));
      check("miss_count", ESZ'(miss_count), ESZ'(m_misses));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_iready"}, ESZ'(iready), '0);
      check({tag, "_ovalid"}, ESZ'(ovalid), '0);
      check({tag, "_read"}, ESZ'(avm_read), '0);
      check({tag, "_address"}, ESZ'(avm_addr), '0);
      check({tag, "_data"}, data, '0);
      check({tag, "_hit_count"}, ESZ'(hit_count), '0);
      check({tag, "_miss_count"}, ESZ'(miss_count), '0);
   endtask

   initial begin
      int n;
      reset      = 1'b1;
      ivalid     = 1'b0;
      index      = '0;
      baseaddr   = '0;
      invalidate = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      check("byteenable", ESZ'(avm_be), ESZ'(2'b11));
      @(negedge clk);
      reset    = 1'b0;
      baseaddr = 32'h1000;

      // Cold miss, then a hit on the same element.
      do_req(2);
      check("first_read", ESZ'(avm_read), ESZ'(1'b1));
      check("first_addr", ESZ'(avm_addr), ESZ'(32'h1048));
      wait_drain();
      check_counters();
      do_req(2);
      wait_drain();
      check_counters();

      // Back-to-back hits, then a same-line conflict.
      do_req(2); do_req(2); do_req(2);
      do_req(18); do_req(2);
      wait_drain();
      check_counters();

      // Alternating waitrequest with 3-cycle read latency.
      wr_mode = 1;
      lat     = 3;
      do_req(5); do_req(21); do_req(5); do_req(5);
      wait_drain();

      // Consumer stall on a filled response.
      or_mode = 2;
      do_req(9);
      n = 0;
      while (!ovalid && n < 2000) begin
         idle_cycles(1);
         n++;
      end
      idle_cycles(5);
      or_mode = 0;
      wait_drain();

      // Invalidate in the middle of a fill, and alongside a hit lookup.
      wr_mode = 0;
      lat     = 1;
      do_req(7);
      idle_cycles(2);
      pulse_inv();
      wait_drain();
      do_req(7);
      wait_drain();
      do_req(7, 1);
      do_req(7);
      wait_drain();
      check_counters();

      // Randomised traffic, including a wrapping base address.
      or_mode = 1;
      wr_mode = 2;
      for (int i = 0; i < 160; i++) begin
         if (i % 50 == 0) begin
            wait_drain();
            baseaddr = (i == 100) ? 32'hFFFF_FF00 : 32'h1000 + 32'($urandom_range(0, 255)) * 32'd4;
         end
         if (i % 20 == 0) lat = $urandom_range(1, 4);
         do_req(32'($urandom_range(0, 47)), ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
         if ($urandom_range(0, 19) == 0) pulse_inv();
      end
      wait_drain();
      or_mode = 0;
      check_counters();

      // Reset in the middle of a burst.
      wr_mode = 0;
      pulse_inv();
      do_req(40);
      idle_cycles(2);
      reset = 1'b1;
      #1;
      check_reset_outputs("midfill_reset");
      sbq.delete();
      model_clear();
      m_hits   = 0;
      m_misses = 0;
      cur_seen = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      reads_at_pop = reads_seen;
      do_req(40);
      wait_drain();
      check_counters();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
